io_request_arbiter: RTL
=======================

Name: io_request_arbiter

Overview:
Shares the single non-cached I/O bus (io_bus_interface master side) among NUM_REQUESTERS core-side I/O request ports, using a round-robin arbiter.
- Accepts ioreq_packet_t-format requests: store, thread_idx, address, value.
- Runs one bus transaction at a time.
- Returns an iorsp_packet_t-format response (core, thread_idx, read_value) to every requester, for both loads and stores.
- Sits between the per-core io_request_queue outputs and the top-level peripheral bus.

Parameters:
NUM_REQUESTERS, 4, number of requesting cores; 1..16, matching the core_id_t range.
THREAD_IDX_WIDTH, 2, width of local_thread_idx_t (clog2 of THREADS_PER_CORE).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ioreq_valid  in  NUM_REQUESTERS  per-requester request pending
ioreq_store  in  NUM_REQUESTERS  per-requester store(1)/load(0)
ioreq_thread_idx  in  NUM_REQUESTERS*THREAD_IDX_WIDTH  per-requester thread index
ioreq_address  in  NUM_REQUESTERS*32  per-requester address
ioreq_value  in  NUM_REQUESTERS*32  per-requester store data
ioreq_ack  out  NUM_REQUESTERS  one-hot, one-cycle accept pulse
io_write_en  out  1  bus write strobe
io_read_en  out  1  bus read strobe
io_address  out  32  bus address
io_write_data  out  32  bus write data
io_read_data  in  32  bus read data, valid the cycle after io_read_en
iorsp_valid  out  1  response valid, one-cycle pulse
iorsp_core  out  4  index of the granted requester (core_id_t)
iorsp_thread_idx  out  THREAD_IDX_WIDTH  echoed thread index
iorsp_read_value  out  32  load data; 0 for stores

Behaviour:
- Everything is sampled on the rising edge of clk. Reset is synchronous and active-high; it has priority over every other event.
- Reset values:
  - ioreq_ack = 0, io_write_en = 0, io_read_en = 0, iorsp_valid = 0.
  - io_address, io_write_data, iorsp_read_value = 0; iorsp_core = 0; iorsp_thread_idx = 0.
  - State = IDLE; round-robin last-grant pointer = NUM_REQUESTERS-1, so requester 0 has first priority.
- State machine, states IDLE, BUS, RESP:
  - IDLE: if any ioreq_valid bit is set, grant the first valid requester searching upward, with wrap-around, from (last_grant+1) mod NUM_REQUESTERS. In the same cycle:
    - combinationally assert ioreq_ack[grant];
    - register store, thread_idx, address, value and the grant index;
    - update last_grant to the grant index;
    - go to BUS.
    If no request is valid, stay in IDLE with all strobes low.
  - BUS: registered outputs drive the bus for exactly one cycle. io_write_en = store, io_read_en = ~store (mutually exclusive), io_address = latched address, io_write_data = latched value. Go to RESP.
  - RESP: strobes low. Assert iorsp_valid for one cycle with:
    - iorsp_core = grant index, zero-extended to 4 bits;
    - iorsp_thread_idx = latched thread index;
    - iorsp_read_value = io_read_data for a load, 32'h0 for a store.
    Go to IDLE.
- Timing:
  - Fixed latency: ack in cycle N, bus strobe in N+1, response in N+2.
  - Earliest next ack is N+3, so peak throughput is one transaction per 3 cycles.
- ioreq_ack is asserted only in IDLE. Requests that are valid during BUS or RESP wait.
- Requester contract: hold valid and the packet fields stable until the ack is seen, then drop valid or present the next request in the following cycle. The arbiter samples the packet only in the ack cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,N-1,0. No requester waits more than NUM_REQUESTERS grants.
- A single requester re-requesting back-to-back gets consecutive grants when no one else is valid.
- io_address and io_write_data hold their last values outside BUS; only the strobes qualify them.
- Reset mid-transaction, in any state: the in-flight transaction is abandoned and no iorsp_valid is produced. Strobes go low on the reset cycle edge. The pointer returns to its reset value.
- When NUM_REQUESTERS=1, the arbiter degenerates to a pass-through with the same 3-cycle sequencing.

Test Plan:
- Reset then a single load: requester 2 load, thread 1, address 0xFFFF0004. Expect ioreq_ack=4'b0100 at cycle N, io_read_en=1 with io_address=0xFFFF0004 at N+1. Bench drives io_read_data=0xDEADBEEF at N+2. Expect iorsp_valid=1, core=2, thread=1, read_value=0xDEADBEEF at N+2.
- Store: requester 0 store, address 0xFFFF0000, value 0x12345678. Expect io_write_en=1, io_read_en=0, io_write_data=0x12345678 at N+1, then iorsp_valid with read_value=0 at N+2.
- Fairness: all 4 requesters held valid for 12 transactions. Expect ack order 0,1,2,3,0,1,2,3,0,1,2,3, with acks exactly 3 cycles apart.
- Wrap and skip: last grant 3, only requesters 1 and 3 valid. Expect grant 1, then 3, then 1.
- Reset mid-operation: assert reset in the BUS cycle of a load. Expect strobes 0 and no iorsp_valid afterward. The next request from requester 3, with requester 0 also valid, grants 0 first (pointer reset).
- Idle stability: no valid for 20 cycles. Expect all strobes, acks and iorsp_valid held at 0.

Source files
------------

// File: rtl/io_request_arbiter.sv
// io_request_arbiter: round-robin sharing of the single non-cached I/O bus among
// NUM_REQUESTERS core request ports, one ack -> bus -> response transaction at a time.
module io_request_arbiter #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int THREAD_IDX_WIDTH = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQUESTERS-1:0]                  ioreq_valid,
    input  logic [NUM_REQUESTERS-1:0]                  ioreq_store,
    input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0] ioreq_thread_idx,
    input  logic [NUM_REQUESTERS*32-1:0]               ioreq_address,
    input  logic [NUM_REQUESTERS*32-1:0]               ioreq_value,
    output logic [NUM_REQUESTERS-1:0]                  ioreq_ack,
    output logic                                       io_write_en,
    output logic                                       io_read_en,
    output logic [31:0]                                io_address,
    output logic [31:0]                                io_write_data,
    input  logic [31:0]                                io_read_data,
    output logic                                       iorsp_valid,
    output logic [3:0]                                 iorsp_core,
    output logic [THREAD_IDX_WIDTH-1:0]                iorsp_thread_idx,
    output logic [31:0]                                iorsp_read_value
);
    localparam int IW = NUM_REQUESTERS > 1 ? $clog2(NUM_REQUESTERS) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               last_q, last_d, grant_q, grant_d, grant, cand;
    logic                        found;
    logic                        store_q, store_d, wr_q, wr_d, rd_q, rd_d;
    logic [THREAD_IDX_WIDTH-1:0] thread_q, thread_d;
    logic [31:0]                 addr_q, addr_d, value_q, value_d;
    logic [THREAD_IDX_WIDTH-1:0] thread_a [NUM_REQUESTERS];
    logic [31:0]                 addr_a   [NUM_REQUESTERS];
    logic [31:0]                 value_a  [NUM_REQUESTERS];

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
        assign thread_a[i] = ioreq_thread_idx[i*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
        assign addr_a[i]   = ioreq_address[i*32 +: 32];
        assign value_a[i]  = ioreq_value[i*32 +: 32];
    end

    // First valid requester searching upward from last_q+1, wrapping around.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_REQUESTERS);
            if (!found && ioreq_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        store_d   = store_q;
        thread_d  = thread_q;
        addr_d    = addr_q;
        value_d   = value_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        ioreq_ack = '0;
        if (state_q == IDLE && found && !reset) begin
            ioreq_ack[grant] = 1'b1;
            last_d           = grant;
            grant_d          = grant;
            store_d          = ioreq_store[grant];
            thread_d         = thread_a[grant];
            addr_d           = addr_a[grant];
            value_d          = value_a[grant];
            wr_d             = ioreq_store[grant];
            rd_d             = !ioreq_store[grant];
            state_d          = BUS;
        end else if (state_q == BUS) begin
            state_d = RESP;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= IW'(NUM_REQUESTERS - 1);
            grant_q  <= '0;
            store_q  <= 1'b0;
            thread_q <= '0;
            addr_q   <= '0;
            value_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            store_q  <= store_d;
            thread_q <= thread_d;
            addr_q   <= addr_d;
            value_q  <= value_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // Address and data are loaded at grant and held; only the strobes qualify them.
    assign io_write_en      = wr_q;
    assign io_read_en       = rd_q;
    assign io_address       = addr_q;
    assign io_write_data    = value_q;
    assign iorsp_valid      = state_q == RESP;
    assign iorsp_core       = iorsp_valid ? 4'(grant_q) : 4'd0;
    assign iorsp_thread_idx = iorsp_valid ? thread_q : '0;
    assign iorsp_read_value = (iorsp_valid && !store_q) ? io_read_data : 32'd0;
endmodule
